usb_ep_in_packet_sender: RTL and testbench

// Drains one endpoint's IN FIFO (pop side of BRAM_FIFO) and answers host IN tokens for the protocol engine.
// Per IN token: STALL, NAK (FIFO empty) or one DATA0/DATA1 packet of at most MAX_PACKET_SIZE bytes.

---
 rtl/usb_ep_in_packet_sender.sv | 166 ++++++++++++++++
 tb/tb_usb_ep_in_packet_sender.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_ep_in_packet_sender.sv
// IN-endpoint packet sender: answers IN tokens with STALL, NAK or one DATA0/DATA1 packet
// drained from the endpoint FIFO. It commits the FIFO read on ACK, rolls it back on timeout, and owns the data toggle.
module usb_ep_in_packet_sender #(
    parameter int MAX_PACKET_SIZE = 64,
    parameter int CNT_WID         = $clog2(MAX_PACKET_SIZE + 1)
) (
    input  logic       clk48_i,
    input  logic       rst_i,
    input  logic       inTokenValid_i,
    input  logic       stall_i,
    input  logic       resetDataToggle_i,
    input  logic       hostAck_i,
    input  logic       hostTimeout_i,
    input  logic       fifoDataAvailable_i,
    input  logic [7:0] fifoData_i,
    output logic       fifoPopData_o,
    output logic       fifoPopTransDone_o,
    output logic       fifoPopTransSuccess_o,
    output logic       txReqSend_o,
    input  logic       txAck_i,
    output logic       txIsHandshake_o,
    output logic [1:0] txPacketId_o,
    output logic       txDataValid_o,
    output logic [7:0] txData_o,
    output logic       txIsLastByte_o,
    input  logic       txDataReady_i,
    output logic       busy_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_HS,
        ST_DATA_START,
        ST_DATA_STREAM,
        ST_WAIT_HS
    } state_t;

    localparam logic [1:0]         PID_NAK   = 2'b10;
    localparam logic [1:0]         PID_STALL = 2'b11;
    localparam logic [CNT_WID-1:0] CNT_MAX   = CNT_WID'(MAX_PACKET_SIZE);
    localparam logic [CNT_WID-1:0] CNT_ONE   = CNT_WID'(1);

    state_t             state_reg,  state_next;
    logic [1:0]         hs_pid_reg, hs_pid_next;
    logic               toggle_reg, toggle_next;
    logic [CNT_WID-1:0] cnt_reg,    cnt_next;
    logic [7:0]         hold_reg,   hold_next;
    logic               busy_reg,   busy_next;
    logic               last_byte;

    always_ff @(posedge clk48_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg  <= ST_IDLE;
            hs_pid_reg <= 2'b00;
            toggle_reg <= 1'b0;
            cnt_reg    <= '0;
            hold_reg   <= 8'h00;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            hs_pid_reg <= hs_pid_next;
            toggle_reg <= toggle_next;
            cnt_reg    <= cnt_next;
            hold_reg   <= hold_next;
            busy_reg   <= busy_next;
        end
    end

    // The held byte is the final one when the packet is full or nothing follows it in the FIFO.
    assign last_byte = (cnt_reg == CNT_MAX) || !fifoDataAvailable_i;

    always_comb begin
        state_next            = state_reg;
        hs_pid_next           = hs_pid_reg;
        toggle_next           = toggle_reg;
        cnt_next              = cnt_reg;
        hold_next             = hold_reg;
        fifoPopData_o         = 1'b0;
        fifoPopTransDone_o    = 1'b0;
        fifoPopTransSuccess_o = 1'b0;
        txReqSend_o           = 1'b0;
        txIsHandshake_o       = 1'b0;
        txPacketId_o          = 2'b00;
        txDataValid_o         = 1'b0;
        txData_o              = 8'h00;
        txIsLastByte_o        = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (inTokenValid_i) begin
                    if (stall_i) begin
                        hs_pid_next = PID_STALL;
                        state_next  = ST_SEND_HS;
                    end else if (!fifoDataAvailable_i) begin
                        hs_pid_next = PID_NAK;
                        state_next  = ST_SEND_HS;
                    end else begin
                        // Pop is combinational on the token, so gate it with the async reset.
                        fifoPopData_o = !rst_i;
                        hold_next     = fifoData_i;
                        cnt_next      = CNT_ONE;
                        state_next    = ST_DATA_START;
                    end
                end
            end

            ST_SEND_HS: begin
                txReqSend_o     = 1'b1;
                txIsHandshake_o = 1'b1;
                txPacketId_o    = hs_pid_reg;
                if (txAck_i) begin
                    state_next = ST_IDLE;
                end
            end

            ST_DATA_START: begin
                txReqSend_o  = 1'b1;
                txPacketId_o = {toggle_reg, 1'b0};
                if (txAck_i) begin
                    state_next = ST_DATA_STREAM;
                end
            end

            ST_DATA_STREAM: begin
                txDataValid_o  = 1'b1;
                txData_o       = hold_reg;
                txIsLastByte_o = last_byte;
                if (txDataReady_i) begin
                    if (last_byte) begin
                        state_next = ST_WAIT_HS;
                    end else begin
                        hold_next     = fifoData_i;
                        fifoPopData_o = 1'b1;
                        cnt_next      = cnt_reg + CNT_ONE;
                    end
                end
            end

            ST_WAIT_HS: begin
                if (hostAck_i) begin
                    fifoPopTransDone_o    = 1'b1;
                    fifoPopTransSuccess_o = 1'b1;
                    toggle_next           = !toggle_reg;
                    cnt_next              = '0;
                    state_next            = ST_IDLE;
                end else if (hostTimeout_i) begin
                    fifoPopTransDone_o = 1'b1;
                    cnt_next           = '0;
                    state_next         = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (resetDataToggle_i) begin
            toggle_next = 1'b0;
        end
        busy_next = (state_next != ST_IDLE);
    end

    assign busy_o = busy_reg;

endmodule

// File: tb/tb_usb_ep_in_packet_sender.sv
// Bench for usb_ep_in_packet_sender: a transaction FIFO model and transmitter model feed the DUT,
// and a scoreboard queue of expected PIDs, bytes and commit/rollback events is checked by a monitor.
module tb_usb_ep_in_packet_sender;

    logic       clk48 = 1'b0;
    logic       rst_i = 1'b1;
    logic       inTokenValid_i = 1'b0;
    logic       stall_i = 1'b0;
    logic       resetDataToggle_i = 1'b0;
    logic       hostAck_i = 1'b0;
    logic       hostTimeout_i = 1'b0;
    logic       fifoDataAvailable_i;
    logic [7:0] fifoData_i;
    logic       fifoPopData_o;
    logic       fifoPopTransDone_o;
    logic       fifoPopTransSuccess_o;
    logic       txReqSend_o;
    logic       txAck_i = 1'b0;
    logic       txIsHandshake_o;
    logic [1:0] txPacketId_o;
    logic       txDataValid_o;
    logic [7:0] txData_o;
    logic       txIsLastByte_o;
    logic       txDataReady_i = 1'b0;
    logic       busy_o;

    always #5 clk48 = ~clk48;

    usb_ep_in_packet_sender #(.MAX_PACKET_SIZE(64)) dut (
        .clk48_i(clk48),
        .rst_i(rst_i),
        .inTokenValid_i(inTokenValid_i),
        .stall_i(stall_i),
        .resetDataToggle_i(resetDataToggle_i),
        .hostAck_i(hostAck_i),
        .hostTimeout_i(hostTimeout_i),
        .fifoDataAvailable_i(fifoDataAvailable_i),
        .fifoData_i(fifoData_i),
        .fifoPopData_o(fifoPopData_o),
        .fifoPopTransDone_o(fifoPopTransDone_o),
        .fifoPopTransSuccess_o(fifoPopTransSuccess_o),
        .txReqSend_o(txReqSend_o),
        .txAck_i(txAck_i),
        .txIsHandshake_o(txIsHandshake_o),
        .txPacketId_o(txPacketId_o),
        .txDataValid_o(txDataValid_o),
        .txData_o(txData_o),
        .txIsLastByte_o(txIsLastByte_o),
        .txDataReady_i(txDataReady_i),
        .busy_o(busy_o)
    );

    // Transactional FIFO model: reads advance rd_ptr, commit moves rd_start, rollback restores rd_ptr.
    logic [7:0] fifo_mem [0:255];
    int rd_ptr = 0;
    int rd_start = 0;
    int wr_ptr = 0;

    assign fifoDataAvailable_i = (rd_ptr != wr_ptr);
    assign fifoData_i          = fifo_mem[rd_ptr];

    always @(posedge clk48 or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr   <= 0;
            rd_start <= 0;
        end else begin
            if (fifoPopTransDone_o) begin
                if (fifoPopTransSuccess_o) rd_start <= rd_ptr;
                else                       rd_ptr   <= rd_start;
            end
            if (fifoPopData_o) rd_ptr <= rd_ptr + 1;
        end
    end

    localparam int K_HS = 0, K_DPID = 1, K_BYTE = 2, K_DONE = 3;
    typedef struct {
        int         kind;
        logic [7:0] val;
        logic       last;
    } item_t;

    item_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    logic  last_seen = 1'b0;
    logic  ready_block = 1'b0;
    int    ready_hold = 0;
    int    stall_at = 0;
    int    pkt_byte = 0;
    logic  prev_stalled = 1'b0;
    logic [7:0] prev_data = 8'h00;

    task automatic push_item(input int kind, input logic [7:0] val, input logic last);
        item_t it;
        it.kind = kind;
        it.val  = val;
        it.last = last;
        exp_q.push_back(it);
    endtask

    task automatic observe(input int kind, input logic [7:0] val, input logic last);
        item_t it;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: got kind=%0d val=%02h last=%0b, required no output", kind, val, last);
        end else begin
            it = exp_q.pop_front();
            if (it.kind != kind || it.val != val || it.last != last) begin
                errors++;
                $display("FAIL scoreboard: got kind=%0d val=%02h last=%0b, required kind=%0d val=%02h last=%0b",
                         kind, val, last, it.kind, it.val, it.last);
            end else begin
                $display("txn kind=%0d val=%02h last=%0b ok", kind, val, last);
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Transmitter model and monitor: drive ack/ready on the falling edge, observe 1 ns later.
    always begin
        @(negedge clk48);
        txAck_i = txReqSend_o;
        if (ready_block) begin
            txDataReady_i = 1'b0;
        end else if (ready_hold > 0) begin
            txDataReady_i = 1'b0;
            ready_hold--;
        end else begin
            txDataReady_i = 1'b1;
        end
        #1;
        if (!rst_i) begin
            if (txReqSend_o && txAck_i) begin
                observe(txIsHandshake_o ? K_HS : K_DPID, {6'b0, txPacketId_o}, 1'b0);
                pkt_byte = 0;
            end
            if (txDataValid_o && prev_stalled) begin
                chk("data_stable", {24'b0, txData_o}, {24'b0, prev_data});
            end
            if (txDataValid_o && txDataReady_i) begin
                observe(K_BYTE, txData_o, txIsLastByte_o);
                pkt_byte++;
                if (txIsLastByte_o) last_seen = 1'b1;
                if (stall_at != 0 && pkt_byte == stall_at) ready_hold = 3;
            end
            if (fifoPopTransDone_o) begin
                observe(K_DONE, {7'b0, fifoPopTransSuccess_o}, 1'b0);
            end
            prev_stalled = txDataValid_o && !txDataReady_i;
            prev_data    = txData_o;
        end else begin
            prev_stalled = 1'b0;
        end
    end

    task automatic load(input logic [7:0] b);
        fifo_mem[wr_ptr] = b;
        wr_ptr++;
    endtask

    task automatic send_token();
        @(negedge clk48);
        inTokenValid_i = 1'b1;
        @(negedge clk48);
        inTokenValid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk48);
            #2;
            n++;
        end while (busy_o && n < 200);
        chk("idle_timeout", {31'b0, busy_o}, 32'd0);
    endtask

    task automatic wait_last();
        int n = 0;
        while (!last_seen && n < 300) begin
            @(negedge clk48);
            #2;
            n++;
        end
        chk("last_byte_timeout", {31'b0, last_seen}, 32'd1);
        last_seen = 1'b0;
    endtask

    task automatic host_resp(input logic ack, input logic tmo, input logic rdt);
        @(negedge clk48);
        hostAck_i = ack;
        hostTimeout_i = tmo;
        resetDataToggle_i = rdt;
        @(negedge clk48);
        hostAck_i = 1'b0;
        hostTimeout_i = 1'b0;
        resetDataToggle_i = 1'b0;
    endtask

    // One IN transaction returning fifo_mem[first +: n] under the given PID.
    task automatic xfer(input logic [1:0] pid, input int first, input int n,
                        input logic ack, input logic tmo, input logic rdt);
        push_item(K_DPID, {6'b0, pid}, 1'b0);
        for (int i = 0; i < n; i++) push_item(K_BYTE, fifo_mem[first + i], (i == n - 1));
        push_item(K_DONE, {7'b0, ack}, 1'b0);
        send_token();
        wait_last();
        host_resp(ack, tmo, rdt);
        wait_idle();
    endtask

    task automatic handshake_only(input logic [1:0] pid, input int exp_rd);
        push_item(K_HS, {6'b0, pid}, 1'b0);
        send_token();
        wait_idle();
        chk("no_pop_rd_ptr", rd_ptr, exp_rd);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk48);
        #1;
        chk("rst_req", {31'b0, txReqSend_o}, 0);
        chk("rst_valid", {31'b0, txDataValid_o}, 0);
        chk("rst_pop", {31'b0, fifoPopData_o}, 0);
        chk("rst_done", {31'b0, fifoPopTransDone_o}, 0);
        chk("rst_busy", {31'b0, busy_o}, 0);
        chk("rst_pid", {30'b0, txPacketId_o}, 0);
        @(negedge clk48);
        rst_i = 1'b0;

        // 1: empty FIFO -> NAK
        handshake_only(2'b10, 0);

        // 2: three bytes DATA0, then one byte DATA1
        load(8'hA1); load(8'hB2); load(8'hC3);
        xfer(2'b00, 0, 3, 1'b1, 1'b0, 1'b0);
        load(8'hD4);
        xfer(2'b10, 3, 1, 1'b1, 1'b0, 1'b0);

        // 3: 70 bytes split 64 + 6, with a 3-cycle ready stall after byte 10
        for (int i = 0; i < 70; i++) load(8'(i + 16));
        stall_at = 10;
        xfer(2'b00, 4, 64, 1'b1, 1'b0, 1'b0);
        stall_at = 0;
        xfer(2'b10, 68, 6, 1'b1, 1'b0, 1'b0);

        // 4: timeout rolls back; retry with ACK and timeout together commits
        load(8'hA1); load(8'hB2); load(8'hC3);
        xfer(2'b00, 74, 3, 1'b0, 1'b1, 1'b0);
        xfer(2'b00, 74, 3, 1'b1, 1'b1, 1'b0);

        // 5: stall with data present, then toggle reset cases
        load(8'h55);
        stall_i = 1'b1;
        handshake_only(2'b11, 77);
        stall_i = 1'b0;
        xfer(2'b10, 77, 1, 1'b1, 1'b0, 1'b0);
        load(8'h66);
        xfer(2'b00, 78, 1, 1'b1, 1'b0, 1'b0);
        @(negedge clk48);
        resetDataToggle_i = 1'b1;
        @(negedge clk48);
        resetDataToggle_i = 1'b0;
        load(8'h77);
        xfer(2'b00, 79, 1, 1'b1, 1'b0, 1'b0);
        load(8'h88);
        xfer(2'b10, 80, 1, 1'b1, 1'b0, 1'b1);
        load(8'h99);
        xfer(2'b00, 81, 1, 1'b1, 1'b0, 1'b0);

        // 6: reset mid-stream, then next packet must be DATA0
        load(8'h11); load(8'h22); load(8'h33);
        ready_block = 1'b1;
        push_item(K_DPID, 8'h02, 1'b0);
        send_token();
        begin
            int n = 0;
            while (!txDataValid_o && n < 20) begin
                @(negedge clk48);
                #2;
                n++;
            end
        end
        repeat (2) @(negedge clk48);
        #2;
        chk("stream_valid", {31'b0, txDataValid_o}, 1);
        chk("stream_data", {24'b0, txData_o}, 32'h11);
        chk("stream_busy", {31'b0, busy_o}, 1);
        @(negedge clk48);
        rst_i = 1'b1;
        wr_ptr = 0;
        #1;
        chk("mid_rst_valid", {31'b0, txDataValid_o}, 0);
        chk("mid_rst_data", {24'b0, txData_o}, 0);
        chk("mid_rst_busy", {31'b0, busy_o}, 0);
        chk("mid_rst_done", {31'b0, fifoPopTransDone_o}, 0);
        repeat (2) @(negedge clk48);
        rst_i = 1'b0;
        ready_block = 1'b0;
        load(8'h5A);
        xfer(2'b00, 0, 1, 1'b1, 1'b0, 1'b0);

        repeat (3) @(negedge clk48);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
